// File: rtl/dwg_pkg.sv
// Shared types, constants and address helpers for the DWG delay-line sequencer.
// Each rail owns half of the 1024-word RAM; the top address bit picks the rail.
package dwg_pkg;

  localparam int LINE_DEPTH    = 512;
  localparam int OFS_W         = $clog2(LINE_DEPTH);
  localparam int RAIL_BIT      = OFS_W;
  localparam int MIN_DELAY_DEF = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    CLR  = 3'd5
  } state_t;

  // Unsigned wrap keeps the tap inside its own rail; it never borrows into the rail bit.
  function automatic logic [OFS_W-1:0] rd_offset(input logic [OFS_W-1:0] wr_ptr,
                                                 input logic [OFS_W-1:0] dly);
    return wr_ptr - dly;
  endfunction

  function automatic logic [RAIL_BIT:0] rail_addr(input logic rail,
                                                  input logic [OFS_W-1:0] ofs);
    return {rail, ofs};
  endfunction

endpackage

// File: rtl/dwg_delay_ctrl.sv
// Sequencer sharing one single-port delay RAM between the two waveguide rails:
// per sample it reads both rail taps, then writes both rails, plus a whole-RAM clear.
module dwg_delay_ctrl
  import dwg_pkg::*;
#(
  parameter int DW        = 18,
  parameter int AW        = 10,
  parameter int MIN_DELAY = MIN_DELAY_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_stb,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [AW-2:0] delay0,
  input  logic [AW-2:0] delay1,
  input  logic          clr_req,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int            OW        = AW - 1;
  localparam logic [OW-1:0] MIN_D     = OW'(MIN_DELAY);
  localparam logic [OW-1:0] PTR_ZERO  = {OW{1'b0}};
  localparam logic [OW-1:0] PTR_ONE   = OW'(1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [DW-1:0] ZERO_D    = {DW{1'b0}};

  state_t        state_r;
  state_t        next_state_s;
  logic [OW-1:0] wr_ptr_r;
  logic [OW-1:0] d1_r;
  logic [DW-1:0] in0_r;
  logic [DW-1:0] in1_r;
  logic [DW-1:0] rd0_r;
  logic [DW-1:0] rd1_r;
  logic          clr_pend_r;
  logic          clr_pend_s;
  logic [OW-1:0] d0_clamp_s;
  logic [OW-1:0] d1_clamp_s;

  // Delay clamping and effective clear request
  always_comb begin
    clr_pend_s = clr_pend_r | clr_req;
    if (delay0 < MIN_D) begin
      d0_clamp_s = MIN_D;
    end else begin
      d0_clamp_s = delay0;
    end
    if (delay1 < MIN_D) begin
      d1_clamp_s = MIN_D;
    end else begin
      d1_clamp_s = delay1;
    end
  end

  // Next-state logic; a strobe in IDLE has priority over a pending clear
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_stb) begin
          next_state_s = RD0;
        end else if (clr_pend_s) begin
          next_state_s = CLR;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD0:     next_state_s = RD1;
      RD1:     next_state_s = WR0;
      WR0:     next_state_s = WR1;
      WR1:     next_state_s = IDLE;
      CLR: begin
        if (ram_addr == LAST_ADDR) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CLR;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy    <= (next_state_s != IDLE);
    end
  end

  // Datapath: RAM port, sample latches, pointer and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r   <= PTR_ZERO;
      d1_r       <= PTR_ZERO;
      in0_r      <= ZERO_D;
      in1_r      <= ZERO_D;
      rd0_r      <= ZERO_D;
      rd1_r      <= ZERO_D;
      clr_pend_r <= 1'b0;
      out0       <= ZERO_D;
      out1       <= ZERO_D;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      ram_addr   <= ADDR_ZERO;
      ram_we     <= 1'b0;
      ram_din    <= ZERO_D;
    end else begin
      out_valid <= 1'b0;
      if (sample_stb && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          clr_pend_r <= clr_pend_s;
          if (sample_stb) begin
            in0_r    <= in0;
            in1_r    <= in1;
            d1_r     <= d1_clamp_s;
            ram_addr <= rail_addr(1'b0, rd_offset(wr_ptr_r, d0_clamp_s));
            ram_we   <= 1'b0;
            ram_din  <= ZERO_D;
          end else if (clr_pend_s) begin
            ram_addr <= ADDR_ZERO;
            ram_we   <= 1'b1;
            ram_din  <= ZERO_D;
          end else begin
            ram_we  <= 1'b0;
            ram_din <= ZERO_D;
          end
        end
        RD0: begin
          clr_pend_r <= clr_pend_s;
          ram_addr   <= rail_addr(1'b1, rd_offset(wr_ptr_r, d1_r));
        end
        RD1: begin
          // Read data lags its address by one cycle: this is the rail-0 tap.
          clr_pend_r <= clr_pend_s;
          rd0_r      <= ram_dout;
          ram_addr   <= rail_addr(1'b0, wr_ptr_r);
          ram_we     <= 1'b1;
          ram_din    <= in0_r;
        end
        WR0: begin
          clr_pend_r <= clr_pend_s;
          rd1_r      <= ram_dout;
          ram_addr   <= rail_addr(1'b1, wr_ptr_r);
          ram_we     <= 1'b1;
          ram_din    <= in1_r;
        end
        WR1: begin
          clr_pend_r <= clr_pend_s;
          ram_we     <= 1'b0;
          ram_din    <= ZERO_D;
          wr_ptr_r   <= wr_ptr_r + PTR_ONE;
          out0       <= rd0_r;
          out1       <= rd1_r;
          out_valid  <= 1'b1;
        end
        CLR: begin
          // Requests arriving mid-clear are absorbed by the clear in progress.
          if (ram_addr == LAST_ADDR) begin
            clr_pend_r <= 1'b0;
            ram_we     <= 1'b0;
            ram_din    <= ZERO_D;
            wr_ptr_r   <= PTR_ZERO;
            rd0_r      <= ZERO_D;
            rd1_r      <= ZERO_D;
            out0       <= ZERO_D;
            out1       <= ZERO_D;
          end else begin
            ram_addr <= ram_addr + ADDR_ONE;
            ram_we   <= 1'b1;
            ram_din  <= ZERO_D;
          end
        end
        default: begin
          ram_we  <= 1'b0;
          ram_din <= ZERO_D;
        end
      endcase
    end
  end

endmodule
